// File: rtl/i2c_target_regs_if.sv
// Local-side register port of the I2C target: parallel read path plus the
// write-commit strobe and bus-activity flag.
interface i2c_target_regs_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;

  modport master (
    output rd_addr,
    input  rd_data, wr_valid, wr_addr, wr_data, busy
  );

  modport slave (
    input  rd_addr,
    output rd_data, wr_valid, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 2**ADDR_W byte register file; the pointer auto-increments
// on every data byte and persists across transactions.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         ADDR_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire              sda,
  input  logic             sclk,
  i2c_target_regs_if.slave regs
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        scl_sync, sda_sync;
  logic              scl_hist, sda_hist;
  logic              scl_now, sda_now;
  logic              scl_rise, scl_fall, start_det, stop_det;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] ptr, ptr_inc;
  logic [6:0]        shreg;
  logic [7:0]        tx;
  logic [2:0]        bit_cnt;
  logic              rw_q, sda_low, tx_pend, busy_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  logic [7:0]        byte_in;
  logic              last_bit, addr_hit, shift_in, commit;

  // Synchronizers reset to the idle-bus level so no false START/STOP follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], sclk};
      sda_sync <= {sda_sync[0], sda};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign scl_now   = scl_sync[1];
  assign sda_now   = sda_sync[1];
  assign scl_rise  = scl_now & ~scl_hist;
  assign scl_fall  = ~scl_now & scl_hist;
  assign start_det = scl_now & scl_hist & sda_hist & ~sda_now;
  assign stop_det  = scl_now & scl_hist & ~sda_hist & sda_now;
  assign ptr_inc   = ptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // In the ACK states sda_low doubles as the phase flag: set means the ACK is
  // already on the bus and the next falling edge ends the ACK slot.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = IDLE;
        ADDR:      if (scl_rise && last_bit) state_d = addr_hit ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall && sda_low)  state_d = rw_q ? RDATA : PTR;
        PTR:       if (scl_rise && last_bit) state_d = PTR_ACK;
        PTR_ACK:   if (scl_fall && sda_low)  state_d = WDATA;
        WDATA:     if (scl_rise && last_bit) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall && sda_low)  state_d = WDATA;
        RDATA:     if (scl_fall && !tx_pend && last_bit) state_d = RACK;
        RACK:      if (scl_rise) state_d = sda_now ? IDLE : RDATA;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_in  = {shreg, sda_now};
    last_bit = (bit_cnt == 3'd7);
    addr_hit = (byte_in[7:1] == DEV_ADDR);
    shift_in = scl_rise && (state_q == ADDR || state_q == PTR || state_q == WDATA);
    commit   = scl_rise && last_bit && (state_q == WDATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      ptr        <= '0;
      shreg      <= '0;
      tx         <= '0;
      bit_cnt    <= '0;
      rw_q       <= 1'b0;
      sda_low    <= 1'b0;
      tx_pend    <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (start_det) begin
        bit_cnt <= '0;
        sda_low <= 1'b0;
        tx_pend <= 1'b0;
      end else if (stop_det) begin
        bit_cnt <= '0;
        sda_low <= 1'b0;
        tx_pend <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        if (shift_in) begin
          shreg   <= byte_in[6:0];
          bit_cnt <= bit_cnt + 1'b1;
        end
        unique case (state_q)
          ADDR: begin
            if (scl_rise && last_bit) begin
              if (addr_hit) begin
                rw_q   <= byte_in[0];
                busy_q <= 1'b1;
              end else begin
                busy_q <= 1'b0;
              end
            end
          end
          PTR: begin
            if (scl_rise && last_bit) ptr <= byte_in[ADDR_W-1:0];
          end
          WDATA: begin
            if (commit) begin
              mem[ptr]   <= byte_in;
              wr_valid_q <= 1'b1;
              wr_addr_q  <= ptr;
              wr_data_q  <= byte_in;
              ptr        <= ptr_inc;
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (!sda_low) begin
                sda_low <= 1'b1;
              end else if (state_q == ADDR_ACK && rw_q) begin
                tx      <= mem[ptr];
                sda_low <= ~mem[ptr][7];
              end else begin
                sda_low <= 1'b0;
              end
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (tx_pend) begin
                tx_pend <= 1'b0;
                sda_low <= ~tx[7];
                bit_cnt <= '0;
              end else if (last_bit) begin
                sda_low <= 1'b0;
              end else begin
                tx      <= {tx[6:0], 1'b0};
                sda_low <= ~tx[6];
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              ptr <= ptr_inc;
              if (!sda_now) begin
                tx      <= mem[ptr_inc];
                tx_pend <= 1'b1;
              end else begin
                busy_q  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda           = sda_low ? 1'b0 : 1'bz;
  assign regs.rd_data  = mem[regs.rd_addr];
  assign regs.wr_valid = wr_valid_q;
  assign regs.wr_addr  = wr_addr_q;
  assign regs.wr_data  = wr_data_q;
  assign regs.busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: an initiator bit-bangs the bus while an array model
// of the register file and pointer predicts every byte and write strobe.
module tb_i2c_target_regs;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int QTR    = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk;
  logic sda_drv_low;
  wire  sda;

  pullup (sda);
  assign sda = sda_drv_low ? 1'b0 : 1'bz;

  i2c_target_regs_if #(.ADDR_W(ADDR_W)) regs_bus ();

  i2c_target_regs #(.DEV_ADDR(7'h50), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sda  (sda),
    .sclk (sclk),
    .regs (regs_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         exp_acks;
    logic [3:0] a0;
    logic [3:0] a1;
  } vec_t;

  int checks = 0;
  int passed = 0;
  int busy_cnt = 0;
  int drive_cnt = 0;
  int pulse_base = 0;
  int last_acks;
  int last_release;
  int model_ptr;

  logic [7:0] model_mem [DEPTH];
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];
  logic [3:0] obs_addr [$];
  logic [7:0] obs_data [$];
  logic [3:0] exp_addr [$];
  logic [7:0] exp_data [$];
  vec_t       vecs [5];

  // Observers: write strobes, busy cycles, and cycles where the target pulls sda low.
  always @(negedge clk) begin
    if (rst_n && regs_bus.wr_valid) begin
      obs_addr.push_back(regs_bus.wr_addr);
      obs_data.push_back(regs_bus.wr_data);
    end
    if (regs_bus.busy) busy_cnt++;
    if (!sda_drv_low && !sda) drive_cnt++;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    model_ptr = 0;
  endtask

  task automatic model_write_byte(input logic [7:0] b);
    model_mem[model_ptr] = b;
    exp_addr.push_back(4'(model_ptr));
    exp_data.push_back(b);
    model_ptr = (model_ptr + 1) % DEPTH;
  endtask

  task automatic model_read_byte(output logic [7:0] b);
    b = model_mem[model_ptr];
    model_ptr = (model_ptr + 1) % DEPTH;
  endtask

  task automatic wait_q();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv_low = 1'b0; wait_q();
    sclk = 1'b1;        wait_q();
    sda_drv_low = 1'b1; wait_q();
    sclk = 1'b0;        wait_q();
  endtask

  task automatic i2c_stop();
    sda_drv_low = 1'b1; wait_q();
    sclk = 1'b1;        wait_q();
    sda_drv_low = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_drv_low = ~b; wait_q();
    sclk = 1'b1;      wait_q();
    s = sda;          wait_q();
    sclk = 1'b0;      wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output int ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    ack = (s == 1'b0) ? 1 : 0;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(~ack, s);
  endtask

  task automatic peek(input int a, output logic [7:0] d);
    regs_bus.rd_addr = 4'(a);
    @(negedge clk);
    d = regs_bus.rd_data;
  endtask

  task automatic check_mem_all(input string name);
    logic [7:0] d;
    for (int a = 0; a < DEPTH; a++) begin
      peek(a, d);
      check_output(name, d, model_mem[a]);
    end
  endtask

  task automatic check_pulses(input string name);
    int n_obs, n_exp;
    n_obs = obs_addr.size();
    n_exp = exp_addr.size();
    check_output({name, "_npulse"}, n_obs, n_exp);
    for (int i = pulse_base; i < n_obs && i < n_exp; i++) begin
      check_output({name, "_waddr"}, obs_addr[i], exp_addr[i]);
      check_output({name, "_wdata"}, obs_data[i], exp_data[i]);
    end
    pulse_base = (n_obs > n_exp) ? n_obs : n_exp;
  endtask

  // START, address/W, pointer, n data bytes from wbuf, STOP; counts ACKs seen.
  task automatic apply_stimulus(input logic [6:0] dev, input logic [7:0] p, input int n);
    int a;
    last_acks = 0;
    i2c_start();
    write_byte({dev, 1'b0}, a); last_acks += a;
    write_byte(p, a);           last_acks += a;
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a);
      last_acks += a;
    end
    i2c_stop();
  endtask

  // Optional pointer phase, repeated START, n reads (last one NACKed), STOP.
  task automatic read_txn(input logic set_ptr, input logic [7:0] p, input int n);
    int a;
    last_acks = 0;
    if (set_ptr) begin
      i2c_start();
      write_byte({7'h50, 1'b0}, a); last_acks += a;
      write_byte(p, a);             last_acks += a;
    end
    i2c_start();
    write_byte({7'h50, 1'b1}, a); last_acks += a;
    for (int i = 0; i < n; i++) read_byte(i != n - 1, rbuf[i]);
    sda_drv_low = 1'b0;
    wait_q();
    last_release = sda ? 1 : 0;
    i2c_stop();
  endtask

  initial begin
    logic [7:0] d;
    int b_cnt, dr_cnt, kind, n, a;
    logic [7:0] p;

    vecs[0] = '{7'h50, 8'h03, 8'hA5, 8'h5A, 4, 4'h3, 4'h4};
    vecs[1] = '{7'h51, 8'h07, 8'h12, 8'h34, 0, 4'h7, 4'h8};
    vecs[2] = '{7'h50, 8'h0F, 8'h11, 8'h22, 4, 4'hF, 4'h0};
    vecs[3] = '{7'h50, 8'h38, 8'hC3, 8'h3C, 4, 4'h8, 4'h9};
    vecs[4] = '{7'h28, 8'h00, 8'hFF, 8'hEE, 0, 4'h0, 4'h1};

    rst_n = 1'b0;
    sclk = 1'b1;
    sda_drv_low = 1'b0;
    regs_bus.rd_addr = '0;
    model_reset();
    repeat (4) @(negedge clk);
    check_output("rst_busy", regs_bus.busy, 0);
    check_output("rst_wr_valid", regs_bus.wr_valid, 0);
    check_output("rst_wr_addr", regs_bus.wr_addr, 0);
    check_output("rst_wr_data", regs_bus.wr_data, 0);
    check_output("rst_sda", sda, 1);
    check_mem_all("rst_mem");
    rst_n = 1'b1;
    wait_q();

    $display("[TB] table-driven write vectors");
    for (int i = 0; i < 5; i++) begin
      b_cnt = busy_cnt;
      dr_cnt = drive_cnt;
      wbuf[0] = vecs[i].d0;
      wbuf[1] = vecs[i].d1;
      apply_stimulus(vecs[i].dev, vecs[i].ptr, 2);
      check_output("vec_acks", last_acks, vecs[i].exp_acks);
      check_output("vec_busy_after_stop", regs_bus.busy, 0);
      if (vecs[i].exp_acks != 0) begin
        model_ptr = int'(vecs[i].ptr) % DEPTH;
        model_write_byte(vecs[i].d0);
        model_write_byte(vecs[i].d1);
        peek(int'(vecs[i].a0), d); check_output("vec_rd0", d, vecs[i].d0);
        peek(int'(vecs[i].a1), d); check_output("vec_rd1", d, vecs[i].d1);
        check_output("vec_busy_seen", (busy_cnt > b_cnt) ? 1 : 0, 1);
      end else begin
        check_output("vec_nomatch_drive", drive_cnt - dr_cnt, 0);
        check_output("vec_nomatch_busy", busy_cnt - b_cnt, 0);
      end
      check_pulses("vec");
    end

    $display("[TB] repeated START read and pointer persistence");
    wbuf[0] = 8'h77;
    apply_stimulus(7'h50, 8'h05, 1);
    model_ptr = 5; model_write_byte(8'h77);
    check_pulses("ptr5");
    read_txn(1'b1, 8'h03, 2);
    check_output("rd2_acks", last_acks, 3);
    check_output("rd2_byte0", rbuf[0], 8'hA5);
    check_output("rd2_byte1", rbuf[1], 8'h5A);
    check_output("rd2_release", last_release, 1);
    check_output("rd2_busy", regs_bus.busy, 0);
    model_ptr = 5;
    read_txn(1'b0, 8'h00, 1);
    check_output("rd_noptr_acks", last_acks, 1);
    check_output("rd_noptr_ptr5", rbuf[0], 8'h77);
    model_ptr = 6;

    $display("[TB] pointer wrap on write and read");
    wbuf[0] = 8'h99;
    apply_stimulus(7'h50, 8'h01, 1);
    model_ptr = 1; model_write_byte(8'h99);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    apply_stimulus(7'h50, 8'h0F, 2);
    model_ptr = 15; model_write_byte(8'h11); model_write_byte(8'h22);
    check_pulses("wrap");
    read_txn(1'b0, 8'h00, 1);
    check_output("wrap_next_is_mem1", rbuf[0], 8'h99);
    read_txn(1'b1, 8'h0F, 2);
    check_output("wrap_rd_f", rbuf[0], 8'h11);
    check_output("wrap_rd_0", rbuf[1], 8'h22);
    model_ptr = 1;

    $display("[TB] STOP in the middle of a data byte");
    i2c_start();
    write_byte({7'h50, 1'b0}, a); check_output("partial_addr_ack", a, 1);
    write_byte(8'h06, a);         check_output("partial_ptr_ack", a, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, d[0]);
    i2c_stop();
    model_ptr = 6;
    check_pulses("partial");
    check_output("partial_busy", regs_bus.busy, 0);
    check_output("partial_sda", sda, 1);
    peek(6, d); check_output("partial_mem6", d, model_mem[6]);
    wbuf[0] = 8'h42;
    apply_stimulus(7'h50, 8'h06, 1);
    model_write_byte(8'h42);
    check_output("after_partial_acks", last_acks, 3);
    peek(6, d); check_output("after_partial_mem6", d, 8'h42);
    check_pulses("after_partial");

    $display("[TB] asynchronous reset while the target drives sda");
    wbuf[0] = 8'h3C;
    apply_stimulus(7'h50, 8'h02, 1);
    model_ptr = 2; model_write_byte(8'h3C);
    check_pulses("pre_reset");
    i2c_start();
    write_byte({7'h50, 1'b0}, a);
    write_byte(8'h02, a);
    i2c_start();
    write_byte({7'h50, 1'b1}, a);
    check_output("reset_rd_addr_ack", a, 1);
    sda_drv_low = 1'b0;
    @(negedge clk);
    check_output("rdata_bit7_driven", sda, 0);
    rst_n = 1'b0;
    #1;
    check_output("reset_sda_release", sda, 1);
    check_output("reset_busy", regs_bus.busy, 0);
    check_output("reset_wr_addr", regs_bus.wr_addr, 0);
    check_output("reset_wr_data", regs_bus.wr_data, 0);
    model_reset();
    check_mem_all("reset_mem");
    sclk = 1'b1;
    wait_q();
    rst_n = 1'b1;
    wait_q();
    wbuf[0] = 8'h81;
    apply_stimulus(7'h50, 8'h04, 1);
    model_ptr = 4; model_write_byte(8'h81);
    check_output("post_reset_acks", last_acks, 3);
    check_pulses("post_reset");
    read_txn(1'b1, 8'h04, 1);
    check_output("post_reset_read", rbuf[0], 8'h81);
    model_ptr = 5;

    $display("[TB] randomized transactions against the model");
    for (int t = 0; t < 12; t++) begin
      kind = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 3));
      p = 8'($urandom);
      if (kind == 0) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        apply_stimulus(7'h50, p, n);
        check_output("rnd_wr_acks", last_acks, n + 2);
        model_ptr = int'(p) % DEPTH;
        for (int i = 0; i < n; i++) model_write_byte(wbuf[i]);
        check_pulses("rnd_wr");
      end else begin
        read_txn(kind == 1, p, n);
        check_output("rnd_rd_acks", last_acks, (kind == 1) ? 3 : 1);
        check_output("rnd_rd_release", last_release, 1);
        if (kind == 1) model_ptr = int'(p) % DEPTH;
        for (int i = 0; i < n; i++) begin
          model_read_byte(d);
          check_output("rnd_rd_byte", rbuf[i], d);
        end
      end
      a = int'($urandom_range(0, DEPTH - 1));
      peek(a, d);
      check_output("rnd_local_rd", d, model_mem[a]);
    end
    check_pulses("final");
    check_mem_all("final_mem");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
